// File: rtl/s3_pipe_ctrl_pkg.sv
// Shared stage-3 control definitions: opcode/func3 encodings, FSM state codes
// and the per-instruction decode record used by the stage-3 controller.
package s3_pipe_ctrl_pkg;

  localparam logic [4:0] OPC_LOAD_5   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM_5  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC_5  = 5'b00101;
  localparam logic [4:0] OPC_STORE_5  = 5'b01000;
  localparam logic [4:0] OPC_OP_5     = 5'b01100;
  localparam logic [4:0] OPC_LUI_5    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH_5 = 5'b11000;
  localparam logic [4:0] OPC_JALR_5   = 5'b11001;
  localparam logic [4:0] OPC_JAL_5    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM_5 = 5'b11100;

  localparam logic [2:0] FNC_BEQ    = 3'b000;
  localparam logic [2:0] FNC_BNE    = 3'b001;
  localparam logic [2:0] FNC_BLT    = 3'b100;
  localparam logic [2:0] FNC_BGE    = 3'b101;
  localparam logic [2:0] FNC_BLTU   = 3'b110;
  localparam logic [2:0] FNC_BGEU   = 3'b111;
  localparam logic [2:0] FNC_CSRRW  = 3'b001;
  localparam logic [2:0] FNC_CSRRWI = 3'b101;

  // State codes are also consumed by the hazard unit, so keep them stable.
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_LD_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_ALU   = 2'd1;
  localparam logic [1:0] PC_JAL   = 2'd2;
  localparam logic [1:0] PC_RST   = 2'd3;

  localparam logic [1:0] WB_MEM   = 2'd0;
  localparam logic [1:0] WB_ALU   = 2'd1;
  localparam logic [1:0] WB_PC4   = 2'd2;

  localparam logic [2:0] MEM_NONE = 3'd0;
  localparam logic [2:0] MEM_LOAD = 3'd1;

  typedef struct packed {
    logic [2:0] mem_sel;
    logic [1:0] wb_sel;
    logic       reg_we;
    logic       csr_we;
  } dec_t;

endpackage

// File: rtl/s3_pipe_ctrl_branch_resolve.sv
// Branch condition resolution from func3 and comparator flags; shared with
// the branch predictor checker.
module s3_branch_resolve
  import s3_pipe_ctrl_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       breq,
  input  logic       brlt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (func3)
      FNC_BEQ:  taken = breq;
      FNC_BNE:  taken = !breq;
      FNC_BLT:  taken = brlt;
      FNC_BGE:  taken = !brlt;
      FNC_BLTU: taken = brlt;
      FNC_BGEU: taken = !brlt;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/s3_pipe_ctrl.sv
// Stage-3 control: decode, branch resolution, and a small FSM that stalls for
// multi-cycle loads and kills younger instructions after a redirect.
module s3_pipe_ctrl
  import s3_pipe_ctrl_pkg::*;
#(
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter bit CSR_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_s3,
  input  logic        valid_s3,
  input  logic        breq,
  input  logic        brlt,
  input  logic        is_jal,
  output logic [1:0]  pc_sel,
  output logic [2:0]  mem_sel,
  output logic [1:0]  wb_sel,
  output logic        reg_we,
  output logic        csr_we,
  output logic        stall,
  output logic        flush
);

  localparam int MAX_LF = (LOAD_LAT > FLUSH_DEPTH) ? LOAD_LAT : FLUSH_DEPTH;
  localparam int CNT_W  = $clog2((MAX_LF > 2) ? MAX_LF : 2);
  localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(LOAD_LAT - 2);
  localparam logic [CNT_W-1:0] FL_INIT = CNT_W'(FLUSH_DEPTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0] opc;
  logic [2:0] f3;
  logic       rd_nz, v, is_load, is_jalr, is_br, br_taken, redirect;
  logic       unused_inst;
  dec_t       dec;

  assign opc         = inst_s3[6:2];
  assign f3          = inst_s3[14:12];
  assign rd_nz       = |inst_s3[11:7];
  assign unused_inst = ^{inst_s3[31:15], inst_s3[1:0]};

  s3_branch_resolve u_br (
    .func3 (f3),
    .breq  (breq),
    .brlt  (brlt),
    .taken (br_taken)
  );

  always_comb begin
    v        = valid_s3 && (state_q != ST_FLUSH);
    is_load  = v && (opc == OPC_LOAD_5);
    is_jalr  = v && (opc == OPC_JALR_5);
    is_br    = v && (opc == OPC_BRANCH_5);
    redirect = is_jalr || (is_br && br_taken);
    dec      = '0;
    if (v) begin
      case (opc)
        OPC_LUI_5, OPC_AUIPC_5, OPC_OP_5, OPC_OPIMM_5: begin
          dec.wb_sel = WB_ALU;
          dec.reg_we = 1'b1;
        end
        OPC_JAL_5, OPC_JALR_5: begin
          dec.wb_sel = WB_PC4;
          dec.reg_we = 1'b1;
        end
        OPC_LOAD_5: begin
          dec.mem_sel = MEM_LOAD;
          dec.wb_sel  = WB_MEM;
          dec.reg_we  = 1'b1;
        end
        OPC_SYSTEM_5: begin
          if (CSR_EN) begin
            dec.wb_sel = WB_ALU;
            dec.reg_we = 1'b1;
            dec.csr_we = (f3 == FNC_CSRRW) || (f3 == FNC_CSRRWI);
          end
        end
        default: dec = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    flush   = 1'b0;
    mem_sel = dec.mem_sel;
    wb_sel  = dec.wb_sel;
    csr_we  = dec.csr_we;
    reg_we  = dec.reg_we && rd_nz;
    if (v && is_jal)   pc_sel = PC_JAL;
    else if (redirect) pc_sel = PC_ALU;
    else               pc_sel = PC_PLUS4;

    case (state_q)
      ST_RUN: begin
        if (is_load && (LOAD_LAT > 1)) begin
          state_d = ST_LD_WAIT;
          cnt_d   = LD_INIT;
          stall   = 1'b1;
          reg_we  = 1'b0;
        end else if (redirect && (FLUSH_DEPTH > 0)) begin
          state_d = ST_FLUSH;
          cnt_d   = FL_INIT;
          flush   = 1'b1;
        end
      end
      // Load data not ready yet: hold the write until the last wait cycle.
      ST_LD_WAIT: begin
        if (cnt_q != '0) begin
          stall  = 1'b1;
          reg_we = 1'b0;
          cnt_d  = cnt_q - 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    if (rst) begin
      pc_sel  = PC_RST;
      mem_sel = MEM_NONE;
      wb_sel  = WB_MEM;
      reg_we  = 1'b0;
      csr_we  = 1'b0;
      stall   = 1'b0;
      flush   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_s3_pipe_ctrl.sv
// Self-checking bench for s3_pipe_ctrl with LOAD_LAT=3, FLUSH_DEPTH=2, CSR_EN=1.
module tb_s3_pipe_ctrl;

  typedef struct packed {
    logic [1:0] pc;
    logic [2:0] mem;
    logic [1:0] wb;
    logic       we;
    logic       csr;
    logic       st;
    logic       fl;
  } exp_t;

  typedef struct {
    string       nm;
    logic        rst;
    logic        vld;
    logic [31:0] inst;
    logic        breq;
    logic        brlt;
    logic        jal;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, valid_s3, breq, brlt, is_jal;
  logic [31:0] inst_s3;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  mem_sel;
  logic        reg_we, csr_we, stall, flush;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  string nm_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  s3_pipe_ctrl #(.LOAD_LAT(3), .FLUSH_DEPTH(2), .CSR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .inst_s3(inst_s3), .valid_s3(valid_s3),
    .breq(breq), .brlt(brlt), .is_jal(is_jal),
    .pc_sel(pc_sel), .mem_sel(mem_sel), .wb_sel(wb_sel),
    .reg_we(reg_we), .csr_we(csr_we), .stall(stall), .flush(flush)
  );

  function automatic exp_t E(input logic [1:0] pc, input logic [2:0] mem,
                             input logic [1:0] wb, input logic we, input logic csr,
                             input logic st, input logic fl);
    exp_t r;
    r.pc = pc; r.mem = mem; r.wb = wb; r.we = we; r.csr = csr; r.st = st; r.fl = fl;
    return r;
  endfunction

  function automatic logic [31:0] I(input logic [6:0] opc, input logic [4:0] rd,
                                    input logic [2:0] f3);
    return {17'h0, f3, rd, opc};
  endfunction

  function automatic vec_t V(input string nm, input logic r, input logic vl,
                             input logic [31:0] in, input logic bq, input logic bl,
                             input logic jl, input exp_t e);
    vec_t x;
    x.nm = nm; x.rst = r; x.vld = vl; x.inst = in; x.breq = bq; x.brlt = bl;
    x.jal = jl; x.e = e;
    return x;
  endfunction

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, OP = 7'b0110011,
                         OPI = 7'b0010011, JAL = 7'b1101111, JALR = 7'b1100111,
                         LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011,
                         SYS = 7'b1110011, BAD = 7'h7F;

  task automatic check();
    exp_t e, a;
    string nm;
    @(negedge clk);
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty");
    end else begin
      e  = sb_q.pop_front();
      nm = nm_q.pop_front();
      a  = {pc_sel, mem_sel, wb_sel, reg_we, csr_we, stall, flush};
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got pc=%0d mem=%0d wb=%0d we=%b csr=%b st=%b fl=%b, want pc=%0d mem=%0d wb=%0d we=%b csr=%b st=%b fl=%b",
                 nm, a.pc, a.mem, a.wb, a.we, a.csr, a.st, a.fl,
                 e.pc, e.mem, e.wb, e.we, e.csr, e.st, e.fl);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic apply(input string nm, input logic r, input logic vl,
                       input logic [31:0] in, input logic bq, input logic bl,
                       input logic jl, input exp_t e);
    rst = r; valid_s3 = vl; inst_s3 = in; breq = bq; brlt = bl; is_jal = jl;
    sb_q.push_back(e);
    nm_q.push_back(nm);
    check();
  endtask

  task automatic do_rst();
    rst = 1'b1; valid_s3 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; valid_s3 = 1'b0; inst_s3 = '0; breq = 1'b0; brlt = 1'b0; is_jal = 1'b0;
    @(posedge clk); #1;

    vecs.push_back(V("rst_beq",     1, 1, I(BR, 0, 3'b000), 1, 0, 0, E(3, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(V("add_x1",      0, 1, I(OP, 1, 3'b000), 0, 0, 0, E(0, 0, 1, 1, 0, 0, 0)));
    vecs.push_back(V("addi_x0",     0, 1, I(OPI, 0, 3'b000), 0, 0, 0, E(0, 0, 1, 0, 0, 0, 0)));
    vecs.push_back(V("lui_x3",      0, 1, I(LUI, 3, 3'b000), 0, 0, 0, E(0, 0, 1, 1, 0, 0, 0)));
    vecs.push_back(V("auipc_x4",    0, 1, I(AUIPC, 4, 3'b000), 0, 0, 0, E(0, 0, 1, 1, 0, 0, 0)));
    vecs.push_back(V("jal_x1",      0, 1, I(JAL, 1, 3'b000), 0, 0, 1, E(2, 0, 2, 1, 0, 0, 0)));
    vecs.push_back(V("jalr_x1",     0, 1, I(JALR, 1, 3'b000), 0, 0, 0, E(1, 0, 2, 1, 0, 0, 1)));
    vecs.push_back(V("sw",          0, 1, I(ST, 5, 3'b010), 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(V("beq_taken",   0, 1, I(BR, 0, 3'b000), 1, 0, 0, E(1, 0, 0, 0, 0, 0, 1)));
    vecs.push_back(V("beq_nt",      0, 1, I(BR, 0, 3'b000), 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(V("bne_taken",   0, 1, I(BR, 0, 3'b001), 0, 0, 0, E(1, 0, 0, 0, 0, 0, 1)));
    vecs.push_back(V("blt_taken",   0, 1, I(BR, 0, 3'b100), 0, 1, 0, E(1, 0, 0, 0, 0, 0, 1)));
    vecs.push_back(V("bge_nt",      0, 1, I(BR, 0, 3'b101), 0, 1, 0, E(0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(V("bgeu_taken",  0, 1, I(BR, 0, 3'b111), 0, 0, 0, E(1, 0, 0, 0, 0, 0, 1)));
    vecs.push_back(V("bltu_isjal",  0, 1, I(BR, 0, 3'b110), 0, 1, 1, E(2, 0, 0, 0, 0, 0, 1)));
    vecs.push_back(V("br_f3_010",   0, 1, I(BR, 0, 3'b010), 1, 1, 0, E(0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(V("csrrw_x0",    0, 1, I(SYS, 0, 3'b001), 0, 0, 0, E(0, 0, 1, 0, 1, 0, 0)));
    vecs.push_back(V("csrrwi_x7",   0, 1, I(SYS, 7, 3'b101), 0, 0, 0, E(0, 0, 1, 1, 1, 0, 0)));
    vecs.push_back(V("csrrs_x5",    0, 1, I(SYS, 5, 3'b010), 0, 0, 0, E(0, 0, 1, 1, 0, 0, 0)));
    vecs.push_back(V("opc_7f",      0, 1, I(BAD, 5, 3'b111), 1, 1, 0, E(0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(V("bubble_jalr", 0, 0, I(JALR, 1, 3'b000), 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(V("lw_first",    0, 1, I(LD, 5, 3'b010), 0, 0, 0, E(0, 1, 0, 0, 0, 1, 0)));

    foreach (vecs[i]) begin
      apply(vecs[i].nm, vecs[i].rst, vecs[i].vld, vecs[i].inst, vecs[i].breq,
            vecs[i].brlt, vecs[i].jal, vecs[i].e);
      do_rst();
    end

    // Release from reset: decode takes over on the very next cycle.
    apply("rel_rst",  1, 1, I(BR, 0, 3'b000), 1, 0, 0, E(3, 0, 0, 0, 0, 0, 0));
    apply("rel_beq",  0, 1, I(BR, 0, 3'b000), 1, 0, 0, E(1, 0, 0, 0, 0, 0, 1));
    do_rst();

    // Redirect kills the next two instructions.
    apply("fl_bne",   0, 1, I(BR, 0, 3'b001), 0, 0, 0, E(1, 0, 0, 0, 0, 0, 1));
    apply("fl_add1",  0, 1, I(OP, 1, 3'b000), 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0));
    apply("fl_add2",  0, 1, I(OP, 1, 3'b000), 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0));
    apply("fl_add3",  0, 1, I(OP, 1, 3'b000), 0, 0, 0, E(0, 0, 1, 1, 0, 0, 0));
    do_rst();

    // Flush counts cycles, including bubbles.
    apply("flb_beq",  0, 1, I(BR, 0, 3'b000), 1, 0, 0, E(1, 0, 0, 0, 0, 0, 1));
    apply("flb_bub",  0, 0, I(OP, 1, 3'b000), 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0));
    apply("flb_add1", 0, 1, I(OP, 1, 3'b000), 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0));
    apply("flb_add2", 0, 1, I(OP, 1, 3'b000), 0, 0, 0, E(0, 0, 1, 1, 0, 0, 0));
    do_rst();

    // Three-cycle load.
    apply("ld_c1",    0, 1, I(LD, 5, 3'b010), 0, 0, 0, E(0, 1, 0, 0, 0, 1, 0));
    apply("ld_c2",    0, 1, I(LD, 5, 3'b010), 0, 0, 0, E(0, 1, 0, 0, 0, 1, 0));
    apply("ld_c3",    0, 1, I(LD, 5, 3'b010), 0, 0, 0, E(0, 1, 0, 1, 0, 0, 0));
    apply("ld_next",  0, 1, I(OP, 1, 3'b000), 0, 0, 0, E(0, 0, 1, 1, 0, 0, 0));

    // Load to x0 never writes.
    apply("ldx0_c1",  0, 1, I(LD, 0, 3'b010), 0, 0, 0, E(0, 1, 0, 0, 0, 1, 0));
    apply("ldx0_c2",  0, 1, I(LD, 0, 3'b010), 0, 0, 0, E(0, 1, 0, 0, 0, 1, 0));
    apply("ldx0_c3",  0, 1, I(LD, 0, 3'b010), 0, 0, 0, E(0, 1, 0, 0, 0, 0, 0));

    // Reset during the load wait restarts the FSM with a fresh count.
    apply("ldr_c1",   0, 1, I(LD, 5, 3'b010), 0, 0, 0, E(0, 1, 0, 0, 0, 1, 0));
    apply("ldr_rst",  1, 1, I(LD, 5, 3'b010), 0, 0, 0, E(3, 0, 0, 0, 0, 0, 0));
    apply("ldr_re1",  0, 1, I(LD, 5, 3'b010), 0, 0, 0, E(0, 1, 0, 0, 0, 1, 0));
    apply("ldr_re2",  0, 1, I(LD, 5, 3'b010), 0, 0, 0, E(0, 1, 0, 0, 0, 1, 0));
    apply("ldr_re3",  0, 1, I(LD, 5, 3'b010), 0, 0, 0, E(0, 1, 0, 1, 0, 0, 0));

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
